// File: rtl/sram_uart_pkg.sv
// Shared register offsets and status/interrupt bit positions for the SRAM-mapped UART FIFO.
// Pure constants and a status-byte packing helper; no state, no latency, no flow control.
package sram_uart_pkg;

  localparam logic [2:0] OFF_DATA = 3'd0;
  localparam logic [2:0] OFF_IER  = 3'd1;
  localparam logic [2:0] OFF_LSR  = 3'd5;

  localparam int LSR_DR    = 0;
  localparam int LSR_TXOVF = 1;
  localparam int LSR_THRE  = 5;
  localparam int LSR_TEMT  = 6;

  localparam int IER_RDA  = 0;
  localparam int IER_TEMT = 1;

  function automatic logic [7:0] lsr_pack(input logic dr, input logic txovf,
                                          input logic thre, input logic temt);
    logic [7:0] v;
    v            = '0;
    v[LSR_DR]    = dr;
    v[LSR_TXOVF] = txovf;
    v[LSR_THRE]  = thre;
    v[LSR_TEMT]  = temt;
    return v;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Circular-buffer FIFO: push/pop take effect on the next edge, head is combinational and reads 0 when empty.
// Push while full and pop while empty are ignored; the caller derives ready/valid from full/empty.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  import sram_uart_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Gating on the pre-edge flags means a pop on a full FIFO cannot admit a same-cycle push.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/sram_uart_fifo.sv
// SRAM-port UART register block (RBR/THR, IER, LSR) over TX/RX FIFOs; reads return one cycle after ena.
// TX bytes written while full are dropped and flagged; RX ready drops when full; streams are valid/ready.
module sram_uart_fifo #(
  parameter logic [63:0] BASE_ADDR = 64'h6000_0000,
  parameter int          RX_DEPTH  = 256,
  parameter int          TX_DEPTH  = 16
) (
  input  logic        clka,
  input  logic        rstn,
  input  logic [63:0] addra,
  input  logic [63:0] dina,
  output logic [63:0] douta,
  input  logic        ena,
  input  logic [7:0]  wea,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);
  import sram_uart_pkg::*;

  localparam int RXA = $clog2(RX_DEPTH);
  localparam int TXA = $clog2(TX_DEPTH);

  logic [2:0]   off;
  logic         rd_en, thr_wr, ier_wr, lsr_rd;
  logic         tx_push, tx_pop, tx_full, tx_empty;
  logic         rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]   tx_head, rx_head, lsr, rd_val;
  logic [TXA:0] tx_count, tx_cnt_nxt;
  logic [RXA:0] rx_count, rx_cnt_nxt;

  logic [63:0]  douta_q, douta_d;
  logic [1:0]   ier_q, ier_d;
  logic         txovf_q, txovf_d;
  logic         irq_q, irq_d;

  logic         unused_bits;
  assign unused_bits = ^{addra[63:3], dina[63:16], dina[15:10], BASE_ADDR};

  // Writes are steered by byte lane; the address only selects which register a read returns.
  assign off    = addra[2:0];
  assign rd_en  = ena && !wea[off];
  assign thr_wr = ena && wea[OFF_DATA];
  assign ier_wr = ena && wea[OFF_IER];
  assign lsr_rd = rd_en && (off == OFF_LSR);

  assign tx_push = thr_wr && !tx_full;
  assign tx_pop  = tx_valid && tx_ready;
  assign rx_push = rx_valid && rx_ready;
  assign rx_pop  = rd_en && (off == OFF_DATA) && !rx_empty;

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i   (clka),
    .rst_ni  (rstn),
    .push_i  (tx_push),
    .data_i  (dina[7:0]),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i   (clka),
    .rst_ni  (rstn),
    .push_i  (rx_push),
    .data_i  (rx_data),
    .pop_i   (rx_pop),
    .data_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_head;
  assign rx_ready = !rx_full;
  assign lsr      = lsr_pack(!rx_empty, txovf_q, !tx_full, tx_empty);
  assign douta    = douta_q;
  assign irq      = irq_q;

  // Post-edge occupancy, so irq reflects the state the FIFOs are about to enter.
  assign tx_cnt_nxt = tx_count + (TXA+1)'(tx_push) - (TXA+1)'(tx_pop);
  assign rx_cnt_nxt = rx_count + (RXA+1)'(rx_push) - (RXA+1)'(rx_pop);

  always_comb begin
    rd_val = 8'h00;
    case (off)
      OFF_DATA: rd_val = rx_head;
      OFF_IER:  rd_val = {6'b0, ier_q};
      OFF_LSR:  rd_val = lsr;
      default:  rd_val = 8'h00;
    endcase

    douta_d = douta_q;
    if (rd_en) begin
      douta_d = '0;
      douta_d[{off, 3'b000} +: 8] = rd_val;
    end

    ier_d = ier_wr ? dina[9:8] : ier_q;

    txovf_d = txovf_q;
    if (thr_wr && tx_full) txovf_d = 1'b1;
    else if (lsr_rd)       txovf_d = 1'b0;

    irq_d = (ier_d[IER_RDA] && (rx_cnt_nxt != '0)) ||
            (ier_d[IER_TEMT] && (tx_cnt_nxt == '0));
  end

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      douta_q <= '0;
      ier_q   <= '0;
      txovf_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      douta_q <= douta_d;
      ier_q   <= ier_d;
      txovf_q <= txovf_d;
      irq_q   <= irq_d;
    end
  end

endmodule
